// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM stage plus the MEM/WB pipeline register. Non-memory instructions pass
//   straight through to the MEM/WB register with one cycle of latency. Loads and
//   stores spend one IDLE cycle and then at least one BUSY cycle. The BUSY cycles
//   run a req/ready handshake with the data memory. While the access is
//   outstanding, the front of the pipeline is held with stall_m. If an access
//   waits too long it is aborted, and the sticky mem_err flag is raised.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   *_m                      EX/MEM register contents (held stable while stall_m=1)
//   dmem_req/we/addr/wdata   data memory request side
//   dmem_rdata/ready         data memory response side
//   stall_m                  hold PC, IF/ID, ID/EX and EX/MEM this cycle
//   result_w, rd_w           MEM/WB register: write-back value and destination
//   reg_write_w              MEM/WB write enable (0 marks a bubble)
//   mem_err                  sticky access-timeout flag, cleared only by reset
module mem_wb_stage #(
    parameter int XLEN     = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] write_data_m,
    input  logic [XLEN-1:0] pc_plus4_m,
    input  logic [XLEN-1:0] ext_imm_m,
    input  logic [4:0]      rd_m,
    input  logic            reg_write_m,
    input  logic            mem_write_m,
    input  logic [1:0]      result_src_m,
    input  logic            lui_m,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ready,
    output logic            stall_m,
    output logic [XLEN-1:0] result_w,
    output logic [4:0]      rd_w,
    output logic            reg_write_w,
    output logic            mem_err
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WCNT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   wcnt_reg;
    logic            is_load;
    logic            mem_op;
    logic            timeout;
    logic [XLEN-1:0] pass_result;

    // lui overrides result_src. A lui is therefore never a load.
    assign is_load = (result_src_m == 2'b01) && !lui_m;
    assign mem_op  = mem_write_m || is_load;
    assign timeout = (wcnt_reg == WCNT_LAST);

    // Address and data come straight from EX/MEM. stall_m keeps them stable
    // for the whole access.
    assign dmem_addr  = alu_result_m;
    assign dmem_wdata = write_data_m;

    // Qualify with rst so the request and the stall fall immediately on reset,
    // even in the middle of an access.
    assign dmem_req = rst && (state_reg == BUSY);
    assign dmem_we  = dmem_req && mem_write_m;

    always_comb begin
        stall_m = 1'b0;
        if (rst) begin
            if (state_reg == IDLE)
                stall_m = mem_op;
            else
                stall_m = !dmem_ready && !timeout;  // the abort cycle releases the pipeline
        end
    end

    // Reserved encoding 11 falls back to the ALU result.
    always_comb begin
        pass_result = alu_result_m;
        if (lui_m)
            pass_result = ext_imm_m;
        else if (result_src_m == 2'b10)
            pass_result = pc_plus4_m;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            wcnt_reg    <= '0;
            result_w    <= '0;
            rd_w        <= '0;
            reg_write_w <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mem_op) begin
                        state_reg   <= BUSY;
                        wcnt_reg    <= '0;
                        reg_write_w <= 1'b0;
                    end else begin
                        result_w    <= pass_result;
                        rd_w        <= rd_m;
                        reg_write_w <= reg_write_m;
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        state_reg   <= IDLE;
                        result_w    <= is_load ? dmem_rdata : alu_result_m;
                        rd_w        <= rd_m;
                        reg_write_w <= reg_write_m;
                    end else if (timeout) begin
                        // Drop the instruction. Nothing is written back.
                        state_reg   <= IDLE;
                        mem_err     <= 1'b1;
                        reg_write_w <= 1'b0;
                    end else begin
                        wcnt_reg    <= wcnt_reg + CW'(1);
                        reg_write_w <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result_m, write_data_m, pc_plus4_m, ext_imm_m;
    logic [4:0]  rd_m;
    logic        reg_write_m, mem_write_m, lui_m;
    logic [1:0]  result_src_m;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ready;
    logic        stall_m;
    logic [31:0] result_w;
    logic [4:0]  rd_w;
    logic        reg_write_w, mem_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32), .WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .pc_plus4_m(pc_plus4_m), .ext_imm_m(ext_imm_m),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
        .result_src_m(result_src_m), .lui_m(lui_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .stall_m(stall_m), .result_w(result_w), .rd_w(rd_w),
        .reg_write_w(reg_write_w), .mem_err(mem_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock. Checks happen 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                          input logic [31:0] imm, input logic [4:0] rd, input logic rw,
                          input logic mw, input logic [1:0] src, input logic lui);
        alu_result_m = alu; write_data_m = wd; pc_plus4_m = pc4; ext_imm_m = imm;
        rd_m = rd; reg_write_m = rw; mem_write_m = mw; result_src_m = src; lui_m = lui;
    endtask

    typedef struct {
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  src;
        logic        lui;
        logic [31:0] exp_res;
        logic [4:0]  exp_rd;
        logic        exp_rw;
    } vec_t;

    vec_t vecs[7];

    int req_cnt, stall_cnt;

    initial begin
        // Non-memory vectors: one-cycle latency, never a stall.
        vecs[0] = '{32'h0000_1234, 32'h0000_0104, 32'h0,         5'd5,  1'b1, 2'b00, 1'b0, 32'h0000_1234, 5'd5,  1'b1};
        vecs[1] = '{32'h0000_0011, 32'h0000_0208, 32'hABCD_0000, 5'd6,  1'b1, 2'b10, 1'b1, 32'hABCD_0000, 5'd6,  1'b1};
        vecs[2] = '{32'h0000_0011, 32'h0000_0208, 32'hABCD_0000, 5'd6,  1'b1, 2'b10, 1'b0, 32'h0000_0208, 5'd6,  1'b1};
        vecs[3] = '{32'hCAFE_F00D, 32'h0000_0300, 32'h1111_0000, 5'd31, 1'b1, 2'b11, 1'b0, 32'hCAFE_F00D, 5'd31, 1'b1};
        vecs[4] = '{32'h0000_0077, 32'h0000_0400, 32'h2222_0000, 5'd0,  1'b1, 2'b00, 1'b0, 32'h0000_0077, 5'd0,  1'b1};
        vecs[5] = '{32'h0000_0099, 32'h0000_0500, 32'h3333_0000, 5'd9,  1'b0, 2'b00, 1'b0, 32'h0000_0099, 5'd9,  1'b0};
        // lui on top of a load encoding is not a memory op.
        vecs[6] = '{32'h0000_0040, 32'h0000_0600, 32'h4444_0000, 5'd3,  1'b1, 2'b01, 1'b1, 32'h4444_0000, 5'd3,  1'b1};

        rst = 1'b0;
        set_op(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        dmem_rdata = 32'h0;
        dmem_ready = 1'b0;
        #12;
        chk("rst_result_w", result_w, 32'h0);
        chk("rst_rd_w", {27'h0, rd_w}, 32'h0);
        chk("rst_reg_write_w", {31'h0, reg_write_w}, 32'h0);
        chk("rst_mem_err", {31'h0, mem_err}, 32'h0);
        chk("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Table vectors. dmem_ready is held high and must be ignored outside BUSY.
        dmem_ready = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 7; i++) begin
            set_op(vecs[i].alu, 32'h0, vecs[i].pc4, vecs[i].imm, vecs[i].rd, vecs[i].rw,
                   1'b0, vecs[i].src, vecs[i].lui);
            #1;
            chk($sformatf("vec%0d_stall", i), {31'h0, stall_m}, 32'h0);
            chk($sformatf("vec%0d_req", i), {31'h0, dmem_req}, 32'h0);
            tick();
            chk($sformatf("vec%0d_result", i), result_w, vecs[i].exp_res);
            chk($sformatf("vec%0d_rd", i), {27'h0, rd_w}, {27'h0, vecs[i].exp_rd});
            chk($sformatf("vec%0d_rw", i), {31'h0, reg_write_w}, {31'h0, vecs[i].exp_rw});
            $display("vec %0d: result_w=0x%08h rd_w=%0d reg_write_w=%0b", i, result_w, rd_w, reg_write_w);
        end
        dmem_ready = 1'b0;

        // Load at 0x40. Ready arrives on the third BUSY cycle.
        set_op(32'h40, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 2'b01, 1'b0);
        req_cnt = 0; stall_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            dmem_ready = (c == 3);
            dmem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            if (dmem_req) begin
                req_cnt++;
                chk("load_addr", dmem_addr, 32'h40);
                chk("load_we", {31'h0, dmem_we}, 32'h0);
            end
            if (stall_m) stall_cnt++;
            tick();
            if (c < 3) chk($sformatf("load_bubble%0d", c), {31'h0, reg_write_w}, 32'h0);
        end
        dmem_ready = 1'b0;
        chk("load_req_cycles", req_cnt, 3);
        chk("load_stall_cycles", stall_cnt, 3);
        chk("load_result", result_w, 32'hDEAD_BEEF);
        chk("load_rd", {27'h0, rd_w}, 32'd7);
        chk("load_rw", {31'h0, reg_write_w}, 32'h1);
        chk("load_req_after", {31'h0, dmem_req}, 32'h0);
        $display("load: result_w=0x%08h req_cycles=%0d stall_cycles=%0d", result_w, req_cnt, stall_cnt);

        // Store at 0x80 with data 0x55. Ready arrives on the first BUSY cycle.
        set_op(32'h80, 32'h55, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0);
        #1;
        chk("store_idle_stall", {31'h0, stall_m}, 32'h1);
        chk("store_idle_req", {31'h0, dmem_req}, 32'h0);
        tick();
        dmem_ready = 1'b1;
        #1;
        chk("store_req", {31'h0, dmem_req}, 32'h1);
        chk("store_we", {31'h0, dmem_we}, 32'h1);
        chk("store_addr", dmem_addr, 32'h80);
        chk("store_wdata", dmem_wdata, 32'h55);
        chk("store_busy_stall", {31'h0, stall_m}, 32'h0);
        tick();
        dmem_ready = 1'b0;
        chk("store_rw", {31'h0, reg_write_w}, 32'h0);
        chk("store_req_after", {31'h0, dmem_req}, 32'h0);
        $display("store: addr=0x80 wdata=0x55 reg_write_w=%0b", reg_write_w);

        // Load that never completes. Expect an abort after 15 BUSY cycles.
        set_op(32'h100, 32'h0, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 2'b01, 1'b0);
        req_cnt = 0; stall_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (dmem_req) req_cnt++;
            if (stall_m) stall_cnt++;
            if (c == 15) chk("abort_stall_low", {31'h0, stall_m}, 32'h0);
            tick();
            chk($sformatf("abort_bubble%0d", c), {31'h0, reg_write_w}, 32'h0);
        end
        chk("abort_req_cycles", req_cnt, 15);
        chk("abort_stall_cycles", stall_cnt, 15);
        chk("abort_mem_err", {31'h0, mem_err}, 32'h1);
        chk("abort_req_after", {31'h0, dmem_req}, 32'h0);
        $display("timeout: req_cycles=%0d mem_err=%0b", req_cnt, mem_err);

        // The next operation proceeds normally, and mem_err stays set.
        set_op(32'h0000_5A5A, 32'h0, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, 2'b00, 1'b0);
        #1;
        chk("post_abort_stall", {31'h0, stall_m}, 32'h0);
        tick();
        chk("post_abort_result", result_w, 32'h0000_5A5A);
        chk("post_abort_rw", {31'h0, reg_write_w}, 32'h1);
        chk("mem_err_sticky", {31'h0, mem_err}, 32'h1);
        $display("after timeout: result_w=0x%08h mem_err=%0b", result_w, mem_err);

        // Reset in the middle of a BUSY access.
        set_op(32'h200, 32'h0, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0, 2'b01, 1'b0);
        tick();
        tick();
        chk("mid_busy_req", {31'h0, dmem_req}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", {31'h0, dmem_req}, 32'h0);
        chk("arst_stall", {31'h0, stall_m}, 32'h0);
        chk("arst_result", result_w, 32'h0);
        chk("arst_rd", {27'h0, rd_w}, 32'h0);
        chk("arst_rw", {31'h0, reg_write_w}, 32'h0);
        chk("arst_mem_err", {31'h0, mem_err}, 32'h0);
        tick();
        rst = 1'b1;
        $display("async reset: req=%0b result_w=0x%08h mem_err=%0b", dmem_req, result_w, mem_err);

        // The load restarts from IDLE after reset is released.
        set_op(32'h300, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0, 2'b01, 1'b0);
        #1;
        chk("restart_idle_stall", {31'h0, stall_m}, 32'h1);
        chk("restart_idle_req", {31'h0, dmem_req}, 32'h0);
        tick();
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1357_9BDF;
        #1;
        chk("restart_req", {31'h0, dmem_req}, 32'h1);
        tick();
        dmem_ready = 1'b0;
        chk("restart_result", result_w, 32'h1357_9BDF);
        chk("restart_rd", {27'h0, rd_w}, 32'd12);
        chk("restart_rw", {31'h0, reg_write_w}, 32'h1);
        $display("restart load: result_w=0x%08h rd_w=%0d", result_w, rd_w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
